// File: rtl/fir_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
//   Shared constants and types for the FIR multiply-accumulate engine.
//   - fir_state_e : engine FSM state encoding
//   - COEF_FRAC   : fractional bits of the Q2.30 coefficients
//   - DC_OFFSET   : mid-scale offset removed from / restored to samples
//   - ROUND_C     : half-LSB added before the fractional shift
//   - SAT_MIN/MAX : unsigned 16-bit result clamp
// ----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } fir_state_e;

    localparam int          NTAPS_DEF = 23;
    localparam int          ACC_W_DEF = 56;

    localparam int          COEF_FRAC = 30;
    localparam logic [15:0] DC_OFFSET = 16'h8000;

    // Round half up: add 2^(COEF_FRAC-1) before the arithmetic shift.
    localparam int unsigned ROUND_C   = 32'd1 << (COEF_FRAC - 1);

    // Pipeline flush after the last address: BRAM read, operand, product.
    localparam int          DRAIN_CYC = 3;

    localparam logic [15:0] SAT_MIN   = 16'h0000;
    localparam logic [15:0] SAT_MAX   = 16'hFFFF;

endpackage

// File: rtl/fir_mac.sv
// ----------------------------------------------------------------------------
// fir_mac
//   Operand register, signed multiply and full-precision accumulate.
//   The valid shift register tracks each tap through the three stages so
//   only real BRAM data ever reaches the accumulator.
//
// Ports
//   clk, rstn   : clock, synchronous active-low reset
//   clr_i       : clear accumulator (entry to RUN)
//   en_i        : a BRAM read is being issued this cycle
//   dc_i        : subtract mid-scale from the sample (DC-offset mode)
//   x_i         : sample read data (unsigned)
//   c_i         : coefficient read data (signed Q2.30)
//   acc_nxt_o   : accumulator next-state value (includes the product
//                 being added this cycle)
// ----------------------------------------------------------------------------
module fir_mac
    import fir_pkg::*;
#(
    parameter int XW    = 16,
    parameter int CW    = 32,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic                    dc_i,
    input  logic [XW-1:0]           x_i,
    input  logic [CW-1:0]           c_i,
    output logic signed [ACC_W-1:0] acc_nxt_o
);

    localparam int SW = XW + 1;      // signed sample operand width
    localparam int PW = SW + CW;     // full product width

    localparam logic [SW-1:0] OFFS = SW'(DC_OFFSET);

    // [0] BRAM data valid, [1] operands valid, [2] product valid
    logic [2:0]              vld_pipe_q;

    logic signed [SW-1:0]    s_d, s_q;
    logic signed [CW-1:0]    c_q;
    logic signed [PW-1:0]    p_d, p_q;
    logic signed [ACC_W-1:0] acc_q;

    always_comb begin
        // In DC mode the unsigned sample is re-centred around zero.
        s_d = {1'b0, x_i} - (dc_i ? OFFS : '0);
        // Both operands sign-extended to the product width; the true
        // product always fits, so the modular result is exact.
        p_d = {{CW{s_q[SW-1]}}, s_q} * {{SW{c_q[CW-1]}}, c_q};
        acc_nxt_o = acc_q + (vld_pipe_q[2] ? {{(ACC_W-PW){p_q[PW-1]}}, p_q}
                                           : '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_pipe_q <= '0;
            s_q        <= '0;
            c_q        <= '0;
            p_q        <= '0;
            acc_q      <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1:0], en_i};
            if (vld_pipe_q[0]) begin
                s_q <= s_d;
                c_q <= c_i;
            end
            if (vld_pipe_q[1]) begin
                p_q <= p_d;
            end
            acc_q <= clr_i ? '0 : acc_nxt_o;
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// ----------------------------------------------------------------------------
// fir_mac_engine
//   FIR multiply-accumulate engine answering the ap_start/ap_done filter
//   handshake. Each run reads NTAPS sample/coefficient pairs, accumulates
//   their products, then rounds, optionally restores the DC offset,
//   saturates to 16 bits and presents the result with a one-cycle ap_done.
//
// Ports
//   clk, rstn          : clock, synchronous active-low reset
//   ap_start           : run request, sampled only while idle
//   ap_done / ap_ready : one-cycle completion pulse (identical)
//   ap_idle            : engine is idle
//   ap_return          : filtered sample, held until the next ap_done
//   x_ant_*            : sample BRAM read port (1-cycle latency)
//   x_coefs_*          : coefficient BRAM read port (1-cycle latency)
//   dcValEn            : DC-offset mode, static during a run
// ----------------------------------------------------------------------------
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int NTAPS           = NTAPS_DEF,
    parameter int XADC_DATA_SIZE  = 16,
    parameter int XANT_ADDR_SIZE  = 5,
    parameter int XCOEF_DATA_SIZE = 32,
    parameter int XCOEF_ADDR_SIZE = 5,
    parameter int ACC_W           = ACC_W_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    output logic [XADC_DATA_SIZE-1:0]  ap_return,
    output logic [XANT_ADDR_SIZE-1:0]  x_ant_address0,
    output logic                       x_ant_ce0,
    input  logic [XADC_DATA_SIZE-1:0]  x_ant_q0,
    output logic [XCOEF_ADDR_SIZE-1:0] x_coefs_address0,
    output logic                       x_coefs_ce0,
    input  logic [XCOEF_DATA_SIZE-1:0] x_coefs_q0,
    input  logic                       dcValEn
);

    // One counter drives both address buses, sized for the wider one.
    localparam int CNT_W = (XANT_ADDR_SIZE > XCOEF_ADDR_SIZE) ?
                           XANT_ADDR_SIZE : XCOEF_ADDR_SIZE;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NTAPS - 1);
    localparam logic [1:0]       LAST_DRN  = 2'(DRAIN_CYC - 1);

    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(ROUND_C);
    localparam logic signed [ACC_W-1:0] OFFS  = ACC_W'(DC_OFFSET);
    localparam logic signed [ACC_W-1:0] SMAX  = ACC_W'(SAT_MAX);

    fir_state_e                 state_q;
    logic [CNT_W-1:0]           addr_q;
    logic                       ce_q;
    logic [1:0]                 dcnt_q;
    logic                       done_q;
    logic                       idle_q;
    logic [XADC_DATA_SIZE-1:0]  ret_q;

    logic                       clr;
    logic signed [ACC_W-1:0]    acc_nxt;
    logic signed [ACC_W-1:0]    rnd_sum;
    logic signed [ACC_W-1:0]    r_sh;
    logic signed [ACC_W-1:0]    r_off;
    logic [XADC_DATA_SIZE-1:0]  sat_d;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign clr = (state_q == ST_IDLE) && ap_start;

    fir_mac #(
        .XW    (XADC_DATA_SIZE),
        .CW    (XCOEF_DATA_SIZE),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (clr),
        .en_i      (ce_q),
        .dc_i      (dcValEn),
        .x_i       (x_ant_q0),
        .c_i       (x_coefs_q0),
        .acc_nxt_o (acc_nxt)
    );

    // Round/offset/saturate works on the accumulator's next value so the
    // result can be registered on the same edge as the final accumulate.
    always_comb begin
        rnd_sum = acc_nxt + RND;
        r_sh    = rnd_sum >>> COEF_FRAC;
        r_off   = r_sh + (dcValEn ? OFFS : '0);
        if (r_off < 0) begin
            sat_d = SAT_MIN;
        end else if (r_off > SMAX) begin
            sat_d = SAT_MAX;
        end else begin
            sat_d = r_off[XADC_DATA_SIZE-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM; every handshake and BRAM output is a register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ce_q    <= 1'b0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
            ret_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ap_start) begin
                        state_q <= ST_RUN;
                        addr_q  <= '0;
                        ce_q    <= 1'b1;
                        idle_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= ST_DRAIN;
                        addr_q  <= '0;
                        ce_q    <= 1'b0;
                        dcnt_q  <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (dcnt_q == LAST_DRN) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                        ret_q   <= sat_d;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    idle_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign ap_done          = done_q;
    assign ap_ready         = done_q;
    assign ap_idle          = idle_q;
    assign ap_return        = ret_q;
    assign x_ant_address0   = addr_q[XANT_ADDR_SIZE-1:0];
    assign x_coefs_address0 = addr_q[XCOEF_ADDR_SIZE-1:0];
    assign x_ant_ce0        = ce_q;
    assign x_coefs_ce0      = ce_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// ----------------------------------------------------------------------------
// tb_fir_mac_engine
//   Directed bench: BRAM models, hand-computed expected results, handshake
//   timing, address sequencing and mid-run reset.
// ----------------------------------------------------------------------------
module tb_fir_mac_engine;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ap_start = 1'b0;
    logic        dcValEn = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [15:0] ap_return;
    logic [4:0]  x_ant_address0, x_coefs_address0;
    logic        x_ant_ce0, x_coefs_ce0;
    logic [15:0] x_ant_q0 = '0;
    logic [31:0] x_coefs_q0 = '0;

    logic [15:0] xmem [0:31];
    logic [31:0] cmem [0:31];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    fir_mac_engine dut (
        .clk              (clk),
        .rstn             (rstn),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .ap_return        (ap_return),
        .x_ant_address0   (x_ant_address0),
        .x_ant_ce0        (x_ant_ce0),
        .x_ant_q0         (x_ant_q0),
        .x_coefs_address0 (x_coefs_address0),
        .x_coefs_ce0      (x_coefs_ce0),
        .x_coefs_q0       (x_coefs_q0),
        .dcValEn          (dcValEn)
    );

    // Single-port BRAMs, one cycle read latency
    always @(posedge clk) begin
        if (x_ant_ce0)   x_ant_q0   <= xmem[x_ant_address0];
        if (x_coefs_ce0) x_coefs_q0 <= cmem[x_coefs_address0];
    end

    always @(negedge clk) if (ap_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] x0, input logic [31:0] c0,
                        input logic [15:0] xall, input logic [31:0] call);
        for (int i = 0; i < 32; i++) begin
            xmem[i] = xall;
            cmem[i] = call;
        end
        xmem[0] = x0;
        cmem[0] = c0;
    endtask

    // One complete run: checks address/ce sequence, latency, result.
    task automatic run(input logic dc, input string tag, input logic [15:0] exp);
        int lat;
        int bad;
        lat = -1;
        bad = 0;
        @(negedge clk);
        dcValEn  = dc;
        ap_start = 1'b1;              // cycle S
        @(negedge clk);
        ap_start = 1'b0;              // cycle S+1
        for (int n = 1; n <= 60; n++) begin
            if (n <= 23) begin
                if (!x_ant_ce0 || !x_coefs_ce0 ||
                    x_ant_address0 != 5'(n-1) || x_coefs_address0 != 5'(n-1)) bad++;
            end else begin
                if (x_ant_ce0 || x_coefs_ce0 ||
                    x_ant_address0 != 5'd0 || x_coefs_address0 != 5'd0) bad++;
            end
            if (ap_done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_lat"},   lat, 27);
        chk({tag, "_ret"},   ap_return, exp);
        chk({tag, "_ready"}, ap_ready, 1);
        chk({tag, "_addr"},  bad, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, ap_done, 0);
        chk({tag, "_idle"},  ap_idle, 1);
        chk({tag, "_hold"},  ap_return, exp);
    endtask

    initial begin
        int d0;
        int found;
        int t [3];

        load(16'h0000, 32'h0, 16'h0000, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_idle",  ap_idle, 1);
        chk("rst_done",  ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_ret",   ap_return, 0);
        chk("rst_ce",    {x_ant_ce0, x_coefs_ce0}, 0);
        chk("rst_addr",  {x_ant_address0, x_coefs_address0}, 0);
        rstn = 1'b1;

        // Data-path vectors
        load(16'h1234, 32'h40000000, 16'h5555, 32'h0);
        run(1'b0, "impulse", 16'h1234);
        load(16'h0100, 32'h02000000, 16'h0100, 32'h02000000);
        run(1'b0, "avg", 16'h00B8);
        load(16'h0003, 32'h20000000, 16'h0003, 32'h0);
        run(1'b0, "round_half", 16'h0002);
        load(16'hFFFF, 32'h7FFFFFFF, 16'hFFFF, 32'h0);
        run(1'b0, "sat_hi", 16'hFFFF);
        load(16'h1000, 32'hC0000000, 16'h1000, 32'h0);
        run(1'b0, "sat_lo", 16'h0000);
        load(16'h9000, 32'h40000000, 16'h1111, 32'h0);
        run(1'b1, "dc_pos", 16'h9000);
        load(16'h9000, 32'hC0000000, 16'h1111, 32'h0);
        run(1'b1, "dc_neg", 16'h7000);
        load(16'h9000, 32'h0, 16'hABCD, 32'h0);
        run(1'b1, "dc_zero", 16'h8000);

        // ap_start pulsed mid-RUN is ignored
        load(16'h1234, 32'h40000000, 16'h5555, 32'h0);
        d0 = done_cnt;
        @(negedge clk);
        dcValEn  = 1'b0;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        repeat (9) @(negedge clk);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        repeat (60) @(negedge clk);
        chk("midpulse_dones", done_cnt - d0, 1);
        chk("midpulse_ret", ap_return, 16'h1234);

        // ap_start held high: one result every 28 cycles
        load(16'h0100, 32'h02000000, 16'h0100, 32'h02000000);
        found = 0;
        @(negedge clk);
        ap_start = 1'b1;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if (ap_done && found < 3) begin
                t[found] = n;
                found++;
            end
            if (found == 3) break;
        end
        ap_start = 1'b0;
        chk("held_found", found, 3);
        chk("held_period1", t[1] - t[0], 28);
        chk("held_period2", t[2] - t[1], 28);
        chk("held_ret", ap_return, 16'h00B8);
        repeat (40) @(negedge clk);

        // Reset at S+10 aborts the run
        load(16'h1234, 32'h40000000, 16'h5555, 32'h0);
        d0 = done_cnt;
        @(negedge clk);
        ap_start = 1'b1;              // S
        @(negedge clk);
        ap_start = 1'b0;              // S+1
        repeat (9) @(negedge clk);    // S+10
        rstn = 1'b0;
        @(negedge clk);               // S+11
        chk("midrst_idle", ap_idle, 1);
        chk("midrst_ret",  ap_return, 0);
        chk("midrst_ce",   {x_ant_ce0, x_coefs_ce0}, 0);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_nodone", done_cnt - d0, 0);
        chk("midrst_ret_hold", ap_return, 0);
        run(1'b0, "post_rst", 16'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
